seq_cla_adder: RTL

- Multi-cycle wide adder sequencer. It sits directly upstream and downstream of the team's 4-bit carry-lookahead slice.
- It latches two WIDTH-bit operands and feeds the slice one nibble per cycle, least significant first. It chains the slice carry through a register and collects each 4-bit result into a sum register.
- It reports completion with a one-cycle done pulse. One combinational slice is reused across cycles instead of instantiating WIDTH/4 slices.

---
 rtl/seq_cla_adder_pkg.sv | 8 +
 rtl/seq_cla_adder.sv | 91 +++++++++
 2 files changed

// File: rtl/seq_cla_adder_pkg.sv
// seq_cla_adder_pkg: shared state encoding and sizing helpers for the sequential CLA adder.
package seq_cla_adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int NIBBLE = 4;
    function automatic int idx_w(input int slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction
endpackage

// File: rtl/seq_cla_adder.sv
// seq_cla_adder: feeds a shared 4-bit lookahead slice one nibble per cycle, chaining its carry
// through a register to build a WIDTH-bit sum with a one-cycle done pulse.
module seq_cla_adder
    import seq_cla_adder_pkg::*;
#(
    parameter int SLICES = 4,
    localparam int WIDTH = NIBBLE * SLICES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              cin,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  sum,
    output logic              cout,
    output logic [NIBBLE-1:0] cla_a,
    output logic [NIBBLE-1:0] cla_b,
    output logic              cla_cin,
    input  logic [NIBBLE-1:0] cla_w,
    input  logic              cla_cout
);
    localparam int IW = idx_w(SLICES);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             last;

    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign last = idx_q == IW'(SLICES - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        cla_a   = '0;
        cla_b   = '0;
        cla_cin = 1'b0;
        if (state_q == RUN) begin
            cla_a   = a_q[NIBBLE*idx_q +: NIBBLE];
            cla_b   = b_q[NIBBLE*idx_q +: NIBBLE];
            cla_cin = carry_q;
            sum_d[NIBBLE*idx_q +: NIBBLE] = cla_w;
            carry_d = cla_cout;
            idx_d   = last ? '0 : idx_q + IW'(1);
            cout_d  = last ? cla_cout : cout_q;
            state_d = last ? DONE : RUN;
        end else if (start) begin
            // IDLE and DONE accept alike, which gives back-to-back adds from DONE
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
endmodule
